dom_and_masked: RTL and testbench

Parametrised domain-oriented-masking (DOM) AND gadget: computes a WIDTH-bit bitwise AND of two Boolean-masked operands split into NSHARES = ORDER+1 shares, secure at probing order ORDER. It is the generalised successor of the fixed one-bit, three-share gadget used in the masked Keccak χ layer. It adds an arbitrary order and width, a valid-qualified pipeline with hold (no register toggling when idle), and aligned registration of the inner-domain terms. It sits between the θ/ρ/π datapath and χ in the masked Keccak core, and is reusable by any masked nonlinear layer.

---
 rtl/dom_pkg.sv | 24 ++
 rtl/dom_cross_term.sv | 23 ++
 rtl/dom_and_masked.sv | 93 +++++++++
 tb/tb_dom_and_masked.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_pkg.sv
// Shared sizing and pair-indexing helpers for the domain-oriented-masking AND gadget.
package dom_pkg;

  localparam int unsigned MAX_ORDER = 4;

  function automatic int unsigned nshares(input int unsigned order);
    return order + 1;
  endfunction

  function automatic int unsigned npairs(input int unsigned order);
    return (order + 1) * order / 2;
  endfunction

  // Index of the unordered share pair {i,j} in the flat randomness word list.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/dom_cross_term.sv
// One resharing register of the DOM AND gadget: c <= (a & b) ^ r when enabled.
module dom_cross_term #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] c
);

  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
    end else if (en) begin
      c <= (a & b) ^ r;
    end
  end

endmodule

// File: rtl/dom_and_masked.sv
// Parametrised DOM AND gadget: masked bitwise AND of two share vectors with
// registered resharing/inner terms and optional registered integration.
module dom_and_masked
  import dom_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned ORDER   = 2,   // legal range 1..MAX_ORDER
  parameter bit          OUT_REG = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [(ORDER+1)*WIDTH-1:0]         x,
  input  logic [(ORDER+1)*WIDTH-1:0]         y,
  input  logic [(ORDER+1)*ORDER/2*WIDTH-1:0] z,
  output logic                               out_valid,
  output logic [(ORDER+1)*WIDTH-1:0]         q
);

  localparam int unsigned NSHARES = nshares(ORDER);

  // terms slot (i,j): inner term p_i on the diagonal, cross term c_ij elsewhere.
  logic [NSHARES*NSHARES*WIDTH-1:0] terms;
  logic [NSHARES*WIDTH-1:0]         integ;
  logic [WIDTH-1:0]                 acc;

  for (genvar i = 0; i < NSHARES; i++) begin : g_row
    for (genvar j = 0; j < NSHARES; j++) begin : g_col
      localparam int unsigned T = (i * NSHARES + j) * WIDTH;
      if (i == j) begin : g_inner
        logic [WIDTH-1:0] p;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            p <= '0;
          end else if (in_valid) begin
            p <= x[i*WIDTH +: WIDTH] & y[i*WIDTH +: WIDTH];
          end
        end
        assign terms[T +: WIDTH] = p;
      end else begin : g_cross
        localparam int unsigned K = pair_idx(i, j, NSHARES);
        dom_cross_term #(.WIDTH(WIDTH)) u_cross (
          .clk  (clk),
          .rst_n(rst_n),
          .en   (in_valid),
          .a    (x[i*WIDTH +: WIDTH]),
          .b    (y[j*WIDTH +: WIDTH]),
          .r    (z[K*WIDTH +: WIDTH]),
          .c    (terms[T +: WIDTH])
        );
      end
    end
  end

  // Fixed left-to-right order: p_i first, then c_ij for ascending j.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    integ = '0;
    acc   = '0;
    for (int unsigned i = 0; i < NSHARES; i++) begin
      acc = terms[(i*NSHARES + i)*WIDTH +: WIDTH];
      for (int unsigned j = 0; j < NSHARES; j++) begin
        if (j != i) acc = acc ^ terms[(i*NSHARES + j)*WIDTH +: WIDTH];
      end
      integ[i*WIDTH +: WIDTH] = acc;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [1:0]               vld;
    logic [NSHARES*WIDTH-1:0] q_r;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
        q_r <= '0;
      end else begin
        vld <= {vld[0], in_valid};
        if (vld[0]) q_r <= integ;
      end
    end
    assign q         = q_r;
    assign out_valid = vld[1];
  end else begin : g_out_comb
    logic vld;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld <= 1'b0;
      else        vld <= in_valid;
    end
    assign q         = integ;
    assign out_valid = vld;
  end

endmodule

// File: tb/tb_dom_and_masked.sv
// Self-checking bench for dom_and_masked: four configurations against a share-level model.
module tb_dom_and_masked;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // A: W4/O2/comb, B: W4/O2/reg (shared inputs); C: W1/O1/comb, D: W1/O4/reg.
  logic        vab, ova, ovb;
  logic [11:0] xab, yab, zab, qa, qb;
  logic        vcd, ovc, ovd, zc;
  logic [1:0]  xc, yc, qc;
  logic [4:0]  xd, yd, qd;
  logic [9:0]  zd;

  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] last_a, last_b;
  logic [1:0]  last_c;
  logic [4:0]  last_d;

  dom_and_masked #(.WIDTH(4), .ORDER(2), .OUT_REG(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vab), .x(xab), .y(yab), .z(zab),
    .out_valid(ova), .q(qa));
  dom_and_masked #(.WIDTH(4), .ORDER(2), .OUT_REG(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vab), .x(xab), .y(yab), .z(zab),
    .out_valid(ovb), .q(qb));
  dom_and_masked #(.WIDTH(1), .ORDER(1), .OUT_REG(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vcd), .x(xc), .y(yc), .z(zc),
    .out_valid(ovc), .q(qc));
  dom_and_masked #(.WIDTH(1), .ORDER(4), .OUT_REG(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(vcd), .x(xd), .y(yd), .z(zd),
    .out_valid(ovd), .q(qd));

  // Position of pair {i,j} when all pairs are listed (0,1),(0,2)..(1,2)..
  function automatic int pair_num(input int n, input int i, input int j);
    int lo, hi, k;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    k  = 0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++) begin
        if (a == lo && b == hi) return k;
        k++;
      end
    return -1;
  endfunction

  function automatic logic [19:0] share(input int w, input int i, input logic [19:0] v);
    logic [19:0] msk;
    msk = (20'd1 << w) - 20'd1;
    return (v >> (i * w)) & msk;
  endfunction

  function automatic logic [19:0] ref_q(input int n, input int w, input logic [19:0] x,
                                        input logic [19:0] y, input logic [39:0] z);
    logic [19:0] res, acc, zk;
    res = '0;
    for (int i = 0; i < n; i++) begin
      acc = share(w, i, x) & share(w, i, y);
      for (int j = 0; j < n; j++) begin
        if (j == i) continue;
        zk  = share(w, 0, 20'(z >> (pair_num(n, i, j) * w)));
        acc = acc ^ (share(w, i, x) & share(w, j, y)) ^ zk;
      end
      res = res | (acc << (i * w));
    end
    return res;
  endfunction

  function automatic logic [3:0] unmask(input int n, input int w, input logic [19:0] v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r ^ share(w, i, v);
    return 4'(r);
  endfunction

  function automatic logic [19:0] mk_shares(input int n, input int w, input logic [3:0] val);
    logic [19:0] s, acc, sh, msk;
    msk = (20'd1 << w) - 20'd1;
    s   = '0;
    acc = '0;
    for (int i = 0; i < n - 1; i++) begin
      sh  = 20'($urandom) & msk;
      s   = s | (sh << (i * w));
      acc = acc ^ sh;
    end
    return s | (((acc ^ 20'(val)) & msk) << ((n - 1) * w));
  endfunction

  task automatic test_reset;
    rst_n = 1'b1; vab = 1'b0; vcd = 1'b0;
    xab = '0; yab = '0; zab = '0; xc = '0; yc = '0; zc = 1'b0; xd = '0; yd = '0; zd = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (qa !== 12'h0) begin n_bad++; $display("FAIL reset_qa got %h want 0", qa); end
    n_vec++; if (qb !== 12'h0) begin n_bad++; $display("FAIL reset_qb got %h want 0", qb); end
    n_vec++; if (qc !== 2'h0) begin n_bad++; $display("FAIL reset_qc got %h want 0", qc); end
    n_vec++; if (qd !== 5'h0) begin n_bad++; $display("FAIL reset_qd got %h want 0", qd); end
    n_vec++; if ({ova, ovb, ovc, ovd} !== 4'b0) begin
      n_bad++; $display("FAIL reset_valid got %b want 0000", {ova, ovb, ovc, ovd});
    end
    rst_n = 1'b1;
    last_a = '0; last_b = '0; last_c = '0; last_d = '0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [11:0] e;
    @(negedge clk);
    xab = 12'hC53; yab = 12'h521; zab = 12'hE97; vab = 1'b1;
    e = 12'(ref_q(3, 4, 20'(xab), 20'(yab), 40'(zab)));
    @(negedge clk);
    vab = 1'b0;
    n_vec++; if (ova !== 1'b1) begin n_bad++; $display("FAIL dir_a_valid got %b want 1", ova); end
    n_vec++; if (qa !== e) begin n_bad++; $display("FAIL dir_a_q got %h want %h", qa, e); end
    n_vec++; if (unmask(3, 4, 20'(qa)) !== 4'h2) begin
      n_bad++; $display("FAIL dir_a_unmasked got %h want 2", unmask(3, 4, 20'(qa)));
    end
    n_vec++; if (ovb !== 1'b0) begin n_bad++; $display("FAIL dir_b_early got %b want 0", ovb); end
    @(negedge clk);
    n_vec++; if (ova !== 1'b0) begin n_bad++; $display("FAIL dir_a_pulse got %b want 0", ova); end
    n_vec++; if (qa !== e) begin n_bad++; $display("FAIL dir_a_hold got %h want %h", qa, e); end
    n_vec++; if (ovb !== 1'b1) begin n_bad++; $display("FAIL dir_b_valid got %b want 1", ovb); end
    n_vec++; if (qb !== e) begin n_bad++; $display("FAIL dir_b_q got %h want %h", qb, e); end
    @(negedge clk);
    n_vec++; if (ovb !== 1'b0) begin n_bad++; $display("FAIL dir_b_pulse got %b want 0", ovb); end
    last_a = e; last_b = e;
  endtask

  task automatic test_back_to_back;
    logic [11:0] ex[16];
    logic [3:0]  exu[16];
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      n_vec++; if (ova !== (t >= 1 && t <= 16)) begin
        n_bad++; $display("FAIL b2b_a_valid t=%0d got %b", t, ova);
      end
      if (t >= 1 && t <= 16) begin
        n_vec++; if (qa !== ex[t-1] || unmask(3, 4, 20'(qa)) !== exu[t-1]) begin
          n_bad++; $display("FAIL b2b_a_q t=%0d got %h want %h", t, qa, ex[t-1]);
        end
      end
      n_vec++; if (ovb !== (t >= 2)) begin
        n_bad++; $display("FAIL b2b_b_valid t=%0d got %b", t, ovb);
      end
      if (t >= 2) begin
        n_vec++; if (qb !== ex[t-2] || unmask(3, 4, 20'(qb)) !== exu[t-2]) begin
          n_bad++; $display("FAIL b2b_b_q t=%0d got %h want %h", t, qb, ex[t-2]);
        end
      end
      if (t < 16) begin
        xab = 12'($urandom); yab = 12'($urandom); zab = 12'($urandom); vab = 1'b1;
        ex[t]  = 12'(ref_q(3, 4, 20'(xab), 20'(yab), 40'(zab)));
        exu[t] = unmask(3, 4, 20'(xab)) & unmask(3, 4, 20'(yab));
      end else begin
        vab = 1'b0;
      end
    end
    last_a = ex[15]; last_b = ex[15];
  endtask

  task automatic test_exhaustive;
    logic [1:0] ec;
    logic [4:0] ed;
    logic       xv, yv;
    for (int v = 0; v < 4; v++) begin
      for (int r = 0; r < 4; r++) begin
        xv = v[1]; yv = v[0];
        @(negedge clk);
        xc = 2'(mk_shares(2, 1, {3'b0, xv})); yc = 2'(mk_shares(2, 1, {3'b0, yv}));
        zc = 1'($urandom);
        xd = 5'(mk_shares(5, 1, {3'b0, xv})); yd = 5'(mk_shares(5, 1, {3'b0, yv}));
        zd = 10'($urandom);
        vcd = 1'b1;
        ec = 2'(ref_q(2, 1, 20'(xc), 20'(yc), 40'(zc)));
        ed = 5'(ref_q(5, 1, 20'(xd), 20'(yd), 40'(zd)));
        @(negedge clk);
        vcd = 1'b0;
        n_vec++; if (ovc !== 1'b1 || qc !== ec) begin
          n_bad++; $display("FAIL exh_c x=%b y=%b got %b/%h want 1/%h", xv, yv, ovc, qc, ec);
        end
        n_vec++; if (unmask(2, 1, 20'(qc)) !== {3'b0, xv & yv}) begin
          n_bad++; $display("FAIL exh_c_unmasked x=%b y=%b got %h", xv, yv, unmask(2, 1, 20'(qc)));
        end
        @(negedge clk);
        n_vec++; if (ovd !== 1'b1 || qd !== ed) begin
          n_bad++; $display("FAIL exh_d x=%b y=%b got %b/%h want 1/%h", xv, yv, ovd, qd, ed);
        end
        n_vec++; if (unmask(5, 1, 20'(qd)) !== {3'b0, xv & yv}) begin
          n_bad++; $display("FAIL exh_d_unmasked x=%b y=%b got %h", xv, yv, unmask(5, 1, 20'(qd)));
        end
        last_c = ec; last_d = ed;
      end
    end
  endtask

  task automatic test_hold;
    vab = 1'b0; vcd = 1'b0;
    for (int t = 0; t < 10; t++) begin
      xab = 12'($urandom); yab = 12'($urandom); zab = 12'($urandom);
      xc = 2'($urandom); yc = 2'($urandom); zc = 1'($urandom);
      xd = 5'($urandom); yd = 5'($urandom); zd = 10'($urandom);
      @(negedge clk);
      n_vec++; if (qa !== last_a || qb !== last_b || qc !== last_c || qd !== last_d) begin
        n_bad++; $display("FAIL hold t=%0d got %h %h %h %h want %h %h %h %h",
                          t, qa, qb, qc, qd, last_a, last_b, last_c, last_d);
      end
      n_vec++; if ({ova, ovb, ovc, ovd} !== 4'b0) begin
        n_bad++; $display("FAIL hold_valid t=%0d got %b want 0000", t, {ova, ovb, ovc, ovd});
      end
    end
  endtask

  task automatic test_zero_rand;
    logic [11:0] e, base, z0, flip, diff;
    logic [3:0]  eu;
    int          nd;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      xab = 12'($urandom); yab = 12'($urandom); zab = '0; vab = 1'b1;
      e  = 12'(ref_q(3, 4, 20'(xab), 20'(yab), 40'(zab)));
      eu = unmask(3, 4, 20'(xab)) & unmask(3, 4, 20'(yab));
      @(negedge clk);
      vab = 1'b0;
      n_vec++; if (qa !== e || unmask(3, 4, 20'(qa)) !== eu) begin
        n_bad++; $display("FAIL zero_z t=%0d got %h want %h", t, qa, e);
      end
    end
    xab = 12'($urandom); yab = 12'($urandom); z0 = 12'($urandom);
    base = 12'(ref_q(3, 4, 20'(xab), 20'(yab), 40'(z0)));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flip = 12'(4'($urandom_range(15, 1))) << (k * 4);
      zab = z0 ^ flip; vab = 1'b1;
      e = 12'(ref_q(3, 4, 20'(xab), 20'(yab), 40'(zab)));
      @(negedge clk);
      vab = 1'b0;
      diff = qa ^ base;
      nd = 0;
      for (int i = 0; i < 3; i++) if (diff[i*4 +: 4] != 4'h0) nd++;
      n_vec++; if (nd !== 2) begin
        n_bad++; $display("FAIL zflip_shares k=%0d got %0d changed want 2", k, nd);
      end
      n_vec++; if (qa !== e || unmask(3, 4, 20'(qa)) !== unmask(3, 4, 20'(base))) begin
        n_bad++; $display("FAIL zflip_q k=%0d got %h want %h", k, qa, e);
      end
      last_a = e;
    end
    @(negedge clk);
    last_b = e;
  endtask

  task automatic test_reset_mid;
    logic [11:0] e;
    @(negedge clk);
    xab = 12'($urandom); yab = 12'($urandom); zab = 12'($urandom); vab = 1'b1;
    @(negedge clk);
    xab = 12'($urandom); yab = 12'($urandom); zab = 12'($urandom);
    n_vec++; if (ova !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got %b want 1", ova); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (qa !== 12'h0 || qb !== 12'h0 || qc !== 2'h0 || qd !== 5'h0) begin
      n_bad++; $display("FAIL rmid_q got %h %h %h %h want 0", qa, qb, qc, qd);
    end
    n_vec++; if ({ova, ovb, ovc, ovd} !== 4'b0) begin
      n_bad++; $display("FAIL rmid_valid got %b want 0000", {ova, ovb, ovc, ovd});
    end
    vab = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (ova !== 1'b0 || ovb !== 1'b0) begin
      n_bad++; $display("FAIL rmid_spurious got %b%b want 00", ova, ovb);
    end
    xab = 12'($urandom); yab = 12'($urandom); zab = 12'($urandom); vab = 1'b1;
    e = 12'(ref_q(3, 4, 20'(xab), 20'(yab), 40'(zab)));
    @(negedge clk);
    vab = 1'b0;
    n_vec++; if (ova !== 1'b1 || qa !== e || ovb !== 1'b0) begin
      n_bad++; $display("FAIL rmid_a got %b/%h want 1/%h, b_valid %b", ova, qa, e, ovb);
    end
    @(negedge clk);
    n_vec++; if (ovb !== 1'b1 || qb !== e || ova !== 1'b0) begin
      n_bad++; $display("FAIL rmid_b got %b/%h want 1/%h, a_valid %b", ovb, qb, e, ova);
    end
    @(negedge clk);
    n_vec++; if (ovb !== 1'b0) begin n_bad++; $display("FAIL rmid_b_pulse got %b want 0", ovb); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_exhaustive();
    test_hold();
    test_zero_rand();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
